// File: rtl/alu_exec_stage.sv
// MIPS execute stage: ALU control decode, 32-bit ALU with zero test, and branch-target adder.
// Every result is captured in the EX/MEM output register, one cycle after the inputs.
module alu_exec_stage #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [1:0]       alu_op,
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic [WIDTH-1:0] pc_plus4,
    input  logic [WIDTH-1:0] branch_offset,
    output logic [3:0]       alu_ctrl,
    output logic [WIDTH-1:0] alu_result,
    output logic             zero,
    output logic [WIDTH-1:0] branch_target
);

    typedef enum logic [3:0] {
        CTRL_AND = 4'b0000,
        CTRL_OR  = 4'b0001,
        CTRL_ADD = 4'b0010,
        CTRL_SUB = 4'b0110,
        CTRL_SLT = 4'b0111,
        CTRL_NOR = 4'b1100,
        CTRL_INV = 4'b1111
    } alu_ctrl_e;

    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_SLT = 6'b101010;
    localparam logic [5:0] FUNCT_NOR = 6'b100111;

    alu_ctrl_e        ctrl_next;
    logic [WIDTH-1:0] result_next;
    logic             zero_next;
    logic [WIDTH-1:0] target_next;
    logic             slt_bit;

    always_comb begin
        ctrl_next = CTRL_ADD;
        unique case (alu_op)
            2'b00: ctrl_next = CTRL_ADD;
            2'b01: ctrl_next = CTRL_SUB;
            2'b11: ctrl_next = CTRL_ADD;
            2'b10: begin
                unique case (funct)
                    FUNCT_ADD: ctrl_next = CTRL_ADD;
                    FUNCT_SUB: ctrl_next = CTRL_SUB;
                    FUNCT_AND: ctrl_next = CTRL_AND;
                    FUNCT_OR:  ctrl_next = CTRL_OR;
                    FUNCT_SLT: ctrl_next = CTRL_SLT;
                    FUNCT_NOR: ctrl_next = CTRL_NOR;
                    default:   ctrl_next = CTRL_INV;
                endcase
            end
            default: ctrl_next = CTRL_ADD;
        endcase
    end

    assign slt_bit = ($signed(src_a) < $signed(src_b));

    // Unused control codes (including the invalid decode) yield 0, so zero reads 1.
    always_comb begin
        result_next = '0;
        case (ctrl_next)
            CTRL_AND: result_next = src_a & src_b;
            CTRL_OR:  result_next = src_a | src_b;
            CTRL_ADD: result_next = src_a + src_b;
            CTRL_SUB: result_next = src_a - src_b;
            CTRL_SLT: result_next = {{(WIDTH-1){1'b0}}, slt_bit};
            CTRL_NOR: result_next = ~(src_a | src_b);
            default:  result_next = '0;
        endcase
    end

    assign zero_next   = (result_next == '0);
    assign target_next = pc_plus4 + branch_offset;

    always_ff @(posedge clk) begin
        if (reset) begin
            alu_ctrl      <= '0;
            alu_result    <= '0;
            zero          <= 1'b0;
            branch_target <= '0;
        end else if (en) begin
            alu_ctrl      <= ctrl_next;
            alu_result    <= result_next;
            zero          <= zero_next;
            branch_target <= target_next;
        end
    end

endmodule

// File: tb/tb_alu_exec_stage.sv
// Bench for alu_exec_stage: directed cases followed by random traffic against a behavioural model.
module tb_alu_exec_stage;

    logic        clk = 1'b0;
    logic        reset, en;
    logic [1:0]  alu_op;
    logic [5:0]  funct;
    logic [31:0] src_a, src_b, pc_plus4, branch_offset;
    logic [3:0]  alu_ctrl;
    logic [31:0] alu_result, branch_target;
    logic        zero;

    int unsigned checks = 0;
    int unsigned errors = 0;

    logic [3:0]  exp_ctrl;
    logic [31:0] exp_res, exp_tgt;
    logic        exp_zero;

    alu_exec_stage #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .en(en), .alu_op(alu_op), .funct(funct),
        .src_a(src_a), .src_b(src_b), .pc_plus4(pc_plus4), .branch_offset(branch_offset),
        .alu_ctrl(alu_ctrl), .alu_result(alu_result), .zero(zero), .branch_target(branch_target)
    );

    always #5 clk = ~clk;

    // Behavioural model: pick the operation by name, then evaluate it with plain arithmetic.
    task automatic model(input logic [1:0] op, input logic [5:0] f, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] pc, input logic [31:0] off);
        string name;
        longint sa, sb;
        if (op == 2'b01) name = "sub";
        else if (op != 2'b10) name = "add";
        else if (f == 6'h20) name = "add";
        else if (f == 6'h22) name = "sub";
        else if (f == 6'h24) name = "and";
        else if (f == 6'h25) name = "or";
        else if (f == 6'h2A) name = "slt";
        else if (f == 6'h27) name = "nor";
        else name = "bad";
        sa = (a >= 32'h8000_0000) ? longint'(a) - 64'sd4294967296 : longint'(a);
        sb = (b >= 32'h8000_0000) ? longint'(b) - 64'sd4294967296 : longint'(b);
        case (name)
            "add": begin exp_ctrl = 4'd2;  exp_res = 32'((64'(a) + 64'(b)) % 64'h1_0000_0000); end
            "sub": begin exp_ctrl = 4'd6;  exp_res = 32'((64'(a) + 64'h1_0000_0000 - 64'(b)) % 64'h1_0000_0000); end
            "and": begin exp_ctrl = 4'd0;  exp_res = a & b; end
            "or":  begin exp_ctrl = 4'd1;  exp_res = a | b; end
            "slt": begin exp_ctrl = 4'd7;  exp_res = (sa < sb) ? 32'd1 : 32'd0; end
            "nor": begin exp_ctrl = 4'd12; exp_res = 32'hFFFF_FFFF ^ (a | b); end
            default: begin exp_ctrl = 4'd15; exp_res = 32'd0; end
        endcase
        exp_zero = (exp_res == 32'd0);
        exp_tgt  = 32'((64'(pc) + 64'(off)) % 64'h1_0000_0000);
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s got %h exp %h", tag, got, want);
        end
    endtask

    task automatic step(input string tag, input logic r, input logic e, input logic [1:0] op,
                        input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] pc, input logic [31:0] off);
        reset = r; en = e; alu_op = op; funct = f;
        src_a = a; src_b = b; pc_plus4 = pc; branch_offset = off;
        @(posedge clk);
        #1;
        if (r) begin
            exp_ctrl = '0; exp_res = '0; exp_zero = 1'b0; exp_tgt = '0;
        end else if (e) begin
            model(op, f, a, b, pc, off);
        end
        check({tag, ".ctrl"},   {28'd0, alu_ctrl},  {28'd0, exp_ctrl});
        check({tag, ".result"}, alu_result,         exp_res);
        check({tag, ".zero"},   {31'd0, zero},      {31'd0, exp_zero});
        check({tag, ".target"}, branch_target,      exp_tgt);
    endtask

    initial begin
        logic [5:0] fl [8];
        fl = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h27, 6'h00, 6'h3F};

        step("rst0", 1, 1, 2'b10, 6'h20, 32'hDEAD_BEEF, 32'h1234_5678, 32'h40, 32'h8);
        step("rst1", 1, 0, 2'b01, 6'h22, 32'h0, 32'h1, 32'h44, 32'hC);
        // Hand-written expectations for the R-type sweep.
        step("add", 0, 1, 2'b10, 6'h20, 32'hF, 32'h5, 32'h0, 32'h0);
        check("add.lit", alu_result, 32'h14);
        step("sub", 0, 1, 2'b10, 6'h22, 32'hF, 32'h5, 32'h0, 32'h0);
        check("sub.lit", alu_result, 32'h0A);
        step("and", 0, 1, 2'b10, 6'h24, 32'hF, 32'h5, 32'h0, 32'h0);
        check("and.lit", alu_result, 32'h05);
        step("or",  0, 1, 2'b10, 6'h25, 32'hF, 32'h5, 32'h0, 32'h0);
        check("or.lit", alu_result, 32'h0F);
        step("nor", 0, 1, 2'b10, 6'h27, 32'hF, 32'h5, 32'h0, 32'h0);
        check("nor.lit", alu_result, 32'hFFFF_FFF0);
        check("nor.ctrl.lit", {28'd0, alu_ctrl}, 32'hC);
        step("slt_neg", 0, 1, 2'b10, 6'h2A, 32'hFFFF_FFFF, 32'h1, 32'h0, 32'h0);
        check("slt_neg.lit", alu_result, 32'h1);
        step("slt_pos", 0, 1, 2'b10, 6'h2A, 32'h1, 32'hFFFF_FFFF, 32'h0, 32'h0);
        check("slt_pos.lit", alu_result, 32'h0);
        step("slt_eq", 0, 1, 2'b10, 6'h2A, 32'h5, 32'h5, 32'h0, 32'h0);
        check("slt_eq.zero.lit", {31'd0, zero}, 32'h1);
        step("beq_eq", 0, 1, 2'b01, 6'h00, 32'h1234, 32'h1234, 32'h0040_0004, 32'h10);
        check("beq_eq.target.lit", branch_target, 32'h0040_0014);
        step("beq_ne", 0, 1, 2'b01, 6'h00, 32'h1234, 32'h1233, 32'h0040_0004, 32'h10);
        check("beq_ne.result.lit", alu_result, 32'h1);
        step("wrap_add", 0, 1, 2'b00, 6'h3F, 32'hFFFF_FFFF, 32'h1, 32'h4, 32'hFFFF_FFF8);
        check("wrap_add.zero.lit", {31'd0, zero}, 32'h1);
        check("wrap_tgt.lit", branch_target, 32'hFFFF_FFFC);
        step("aluop11", 0, 1, 2'b11, 6'h22, 32'h7, 32'h9, 32'h100, 32'h4);
        step("invalid", 0, 1, 2'b10, 6'h00, 32'h7, 32'h9, 32'h100, 32'h4);
        check("invalid.ctrl.lit", {28'd0, alu_ctrl}, 32'hF);

        // Stall: hold the add result while new inputs are presented.
        step("ld_add", 0, 1, 2'b10, 6'h20, 32'hF, 32'h5, 32'h8, 32'h8);
        for (int i = 0; i < 3; i++)
            step("stall", 0, 0, 2'b10, 6'h22, 32'h100, 32'h1, 32'h20, 32'h20);
        check("stall.hold.lit", alu_result, 32'h14);
        step("unstall", 0, 1, 2'b10, 6'h22, 32'h100, 32'h1, 32'h20, 32'h20);
        check("unstall.lit", alu_result, 32'hFF);
        step("stall2", 0, 0, 2'b10, 6'h24, 32'h3, 32'h3, 32'h0, 32'h0);
        step("rst_stall", 1, 0, 2'b10, 6'h24, 32'h3, 32'h3, 32'h0, 32'h0);
        check("rst_stall.lit", alu_result, 32'h0);

        for (int i = 0; i < 300; i++) begin
            logic [31:0] a, b;
            logic [1:0]  op;
            logic [5:0]  f;
            a  = $urandom;
            b  = ($urandom_range(0, 5) == 0) ? a : $urandom;
            if ($urandom_range(0, 3) == 0) a = a ^ 32'h8000_0000;
            op = 2'($urandom_range(0, 3));
            f  = ($urandom_range(0, 4) == 0) ? 6'($urandom) : fl[$urandom_range(0, 7)];
            step("rand", ($urandom_range(0, 19) == 0), ($urandom_range(0, 4) != 0),
                 op, f, a, b, $urandom, $urandom);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_exec_stage.md
Name: alu_exec_stage

Overview:
- Execute-stage block of the MIPS datapath.
- Decodes ALU control from the main-control ALUOp and the instruction funct field, then performs the 32-bit ALU operation and the zero test.
- Computes the branch target as PC+4 plus the pre-shifted branch offset.
- All results are captured in an output register (EX/MEM boundary), so they are available one clock after the inputs are presented.

Parameters:
- WIDTH, 32, datapath width of operands, result, PC and offset.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high; clears all output registers.
- en  in  1  capture enable; 0 holds every output register (stall).
- alu_op  in  2  ALUOp from the main control unit.
- funct  in  6  instruction bits [5:0].
- src_a  in  WIDTH  ALU operand A (register file read data 1).
- src_b  in  WIDTH  ALU operand B (after the ALUSrc mux).
- pc_plus4  in  WIDTH  PC+4 of the instruction.
- branch_offset  in  WIDTH  sign-extended immediate, already shifted left by 2.
- alu_ctrl  out  4  registered decoded ALU control code.
- alu_result  out  WIDTH  registered ALU result.
- zero  out  1  registered flag, 1 when the ALU result is 0.
- branch_target  out  WIDTH  registered pc_plus4 + branch_offset.

Behaviour:
- ALU control decode (combinational):
  - alu_op 00 -> 0010 (add; loads/stores).
  - alu_op 01 -> 0110 (sub; beq).
  - alu_op 11 -> 0010 (add).
  - alu_op 10 -> decode on funct:
    - 100000 -> 0010 (add)
    - 100010 -> 0110 (sub)
    - 100100 -> 0000 (and)
    - 100101 -> 0001 (or)
    - 101010 -> 0111 (slt)
    - 100111 -> 1100 (nor)
    - any other funct -> 1111 (invalid)
- ALU operations (combinational, by control code):
  - 0000 -> a & b
  - 0001 -> a | b
  - 0010 -> a + b, modulo 2^WIDTH
  - 0110 -> a - b, modulo 2^WIDTH
  - 0111 -> 1 if a < b as signed two's complement, else 0 (zero-extended)
  - 1100 -> ~(a | b)
  - any other code -> result 0
- Add and sub wrap silently; no overflow or carry flag and no trap.
- zero = (ALU result == 0). With an invalid code the result is 0, so zero = 1.
- Branch adder: pc_plus4 + branch_offset, modulo 2^WIDTH. Wrap-around is permitted (e.g. a negative offset past address 0 wraps).
- Registering:
  - On the rising edge with reset=1: alu_ctrl=0000, alu_result=0, zero=0, branch_target=0.
  - Otherwise, when en=1: all four outputs load the combinational values of the current inputs.
  - When en=0: all outputs hold.
  - reset has priority over en.
- Latency is exactly 1 cycle from input to output. Back-to-back inputs give one result per cycle.
- Reset asserted mid-stream discards the value being captured. The first valid output appears 1 cycle after the first enabled edge following reset deassertion.
- No combinational path from any input to any output.

Test Plan:
- Reset: reset=1 for 2 cycles with arbitrary inputs -> all outputs 0 (zero=0); release reset -> outputs follow the inputs after 1 edge.
- R-type sweep (alu_op=10), src_a=0x0000000F, src_b=0x00000005:
  - add -> 0x14
  - sub -> 0x0A
  - and -> 0x05
  - or -> 0x0F
  - nor -> 0xFFFFFFF0
  - alu_ctrl shows 0010/0110/0000/0001/1100 respectively.
- SLT signed:
  - a=0xFFFFFFFF, b=0x00000001 -> result 1.
  - a=0x00000001, b=0xFFFFFFFF -> result 0.
  - a=b=5 -> result 0 and zero=1.
- Branch compare (alu_op=01):
  - a=b=0x1234 -> result 0, zero=1.
  - a=0x1234, b=0x1233 -> result 1, zero=0.
  - branch_target = 0x00400004 + 0x00000010 = 0x00400014.
- Wrap and defaults:
  - alu_op=00, a=0xFFFFFFFF, b=1 -> result 0, zero=1.
  - pc_plus4=0x00000004, offset=0xFFFFFFF8 -> target 0xFFFFFFFC.
  - alu_op=10, funct=000000 -> alu_ctrl 1111, result 0, zero=1.
- Stall: load add (result 0x14), then en=0 with new inputs for 3 cycles -> outputs hold 0x14; en=1 -> the new result appears next edge; assert reset during en=0 -> outputs clear to 0.
